// File: rtl/rom_scan_ctrl_if.sv
// Bundles the scan controller's request, ROM read port and output stream.
// The master modport is the driving side; the slave modport belongs to the controller.
interface rom_scan_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 4
);
  logic          start;
  logic [AW-2:0] base;
  logic [AW-2:0] len;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-2:0] out_addr;
  logic          busy;
  logic          done;

  modport master (
    output start, base, len, rom_data, out_ready,
    input  rom_en, rom_addr, out_valid, out_data, out_addr, busy, done
  );

  modport slave (
    input  start, base, len, rom_data, out_ready,
    output rom_en, rom_addr, out_valid, out_data, out_addr, busy, done
  );
endinterface

// File: rtl/rom_scan_ctrl.sv
// Streams a window of a registered-output ROM into a small FIFO feeding a valid/ready consumer.
// Reads are throttled so every returning word is guaranteed a free queue slot.
module rom_scan_ctrl #(
  parameter int AW = 5,
  parameter int DW = 4,
  parameter int QD = 2
) (
  input logic            clk,
  input logic            rst_n,
  rom_scan_ctrl_if.slave bus
);
  localparam int BW = AW - 1;
  localparam int PW = $clog2(QD);
  localparam logic [PW-1:0] LAST_P = PW'(QD - 1);
  localparam logic [3:0]    QD_W   = 4'(QD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic          w_issue;
  logic          w_pop;
  logic          w_done_nxt;
  logic [3:0]    w_occ;

  logic [BW-1:0] r_issue_addr;
  logic [BW-1:0] r_last_addr;
  logic [AW-1:0] r_rem;
  logic          r_pend;
  logic [BW-1:0] r_pend_addr;
  logic          r_busy;
  logic          r_done;

  logic [DW-1:0] r_q_data [QD];
  logic [BW-1:0] r_q_addr [QD];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [2:0]    r_cnt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] n;
    if (p == LAST_P) begin
      n = {PW{1'b0}};
    end else begin
      n = p + PW'(1);
    end
    return n;
  endfunction

  // Occupancy seen by a read issued now counts this cycle's pop, which keeps full rate at QD=2
  always_comb begin
    w_pop       = (r_cnt != 3'd0) && bus.out_ready;
    w_occ       = {1'b0, r_cnt} + {3'b000, r_pend} - {3'b000, w_pop};
    w_issue     = 1'b0;
    w_done_nxt  = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if ((r_rem != {AW{1'b0}}) && (w_occ < QD_W)) begin
          w_issue = 1'b1;
        end else begin
          w_issue = 1'b0;
        end
        if (w_issue && (r_rem == AW'(1))) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_pop && (r_cnt == 3'd1) && !r_pend) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Scan bookkeeping: next address, reads left, and the read whose data arrives next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_addr <= {BW{1'b0}};
      r_last_addr  <= {BW{1'b0}};
      r_rem        <= {AW{1'b0}};
      r_pend       <= 1'b0;
      r_pend_addr  <= {BW{1'b0}};
    end else begin
      if ((r_state == S_IDLE) && bus.start) begin
        r_issue_addr <= bus.base;
        r_rem        <= (bus.len == {BW{1'b0}}) ? {1'b1, {BW{1'b0}}} : {1'b0, bus.len};
      end else if (w_issue) begin
        r_issue_addr <= r_issue_addr + BW'(1);
        r_rem        <= r_rem - AW'(1);
        r_last_addr  <= r_issue_addr;
      end
      r_pend <= w_issue;
      if (w_issue) begin
        r_pend_addr <= r_issue_addr;
      end
    end
  end

  // Output FIFO: the returning ROM word is pushed with its address; head pops on transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QD; i++) begin
        r_q_data[i] <= {DW{1'b0}};
        r_q_addr[i] <= {BW{1'b0}};
      end
      r_wp  <= {PW{1'b0}};
      r_rp  <= {PW{1'b0}};
      r_cnt <= 3'd0;
    end else begin
      if (r_pend) begin
        r_q_data[r_wp] <= bus.rom_data;
        r_q_addr[r_wp] <= r_pend_addr;
        r_wp           <= ptr_inc(r_wp);
      end
      if (w_pop) begin
        r_rp <= ptr_inc(r_rp);
      end
      r_cnt <= r_cnt + {2'b00, r_pend} - {2'b00, w_pop};
    end
  end

  // Status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= w_done_nxt;
    end
  end

  assign bus.rom_en    = w_issue;
  assign bus.rom_addr  = {1'b0, (w_issue ? r_issue_addr : r_last_addr)};
  assign bus.out_valid = (r_cnt != 3'd0);
  assign bus.out_data  = r_q_data[r_rp];
  assign bus.out_addr  = r_q_addr[r_rp];
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
endmodule

// File: tb/tb_rom_scan_ctrl.sv
// Randomised bench for rom_scan_ctrl: a ROM model feeds the DUT and every transfer is
// compared against the address/data list implied by base, len and the ROM contents.
module tb_rom_scan_ctrl;
  localparam int AW = 5;
  localparam int DW = 4;
  localparam int QD = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_scan_ctrl_if #(.AW(AW), .DW(DW)) bus ();
  rom_scan_ctrl #(.AW(AW), .DW(DW), .QD(QD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [DW-1:0] rom [0:15];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int msb_bad  = 0;
  int obs_addr[$], obs_data[$], obs_cyc[$], en_cyc[$], done_cyc[$], done_busy[$];
  int exp_addr[$], exp_data[$];

  always @(posedge clk) cyc <= cyc + 1;

  // registered-output ROM: data appears the cycle after rom_en
  always @(posedge clk) if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr[AW-2:0]];

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.out_valid && bus.out_ready) begin
        obs_addr.push_back(int'(bus.out_addr));
        obs_data.push_back(int'(bus.out_data));
        obs_cyc.push_back(cyc);
      end
      if (bus.rom_en) begin
        en_cyc.push_back(cyc);
        if (bus.rom_addr[AW-1]) msb_bad++;
      end
      if (bus.done) begin
        done_cyc.push_back(cyc);
        done_busy.push_back(int'(bus.busy));
      end
    end
  end

  function automatic void build_exp(input int b, input int l);
    int n;
    exp_addr.delete();
    exp_data.delete();
    n = (l == 0) ? 16 : l;
    for (int k = 0; k < n; k++) begin
      exp_addr.push_back((b + k) % 16);
      exp_data.push_back(int'(rom[(b + k) % 16]));
    end
  endfunction

  task automatic start_scan(input int b, input int l, output int s);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    bus.start = 1'b1;
    bus.base  = 4'(b);
    bus.len   = 4'(l);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.base  = 4'($urandom);
    bus.len   = 4'($urandom);
    s = cyc;
  endtask

  task automatic drive_until_done(input int max_cyc, input int rmode, output bit timeout);
    int d0;
    d0 = done_cyc.size();
    timeout = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #1;
      bus.out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (done_cyc.size() != d0) begin
        timeout = 1'b0;
        break;
      end
    end
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.base = 4'd0; bus.len = 4'd0; bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) rom[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.rom_en !== 1'b0) begin failures++; $display("FAIL reset_rom_en got=%0b exp=0", bus.rom_en); end
    checks++; if (bus.rom_addr !== 5'd0) begin failures++; $display("FAIL reset_rom_addr got=%0d exp=0", bus.rom_addr); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.out_data !== 4'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", bus.out_data); end
    checks++; if (bus.out_addr !== 4'd0) begin failures++; $display("FAIL reset_out_addr got=%0d exp=0", bus.out_addr); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
  endtask

  // Full-rate scans with exact cycle timing; the first one starts on the reset-release edge
  task automatic test_full_rate(input int b, input int l);
    int s, o0, e0, d0, n;
    bit to;
    build_exp(b, l);
    n  = exp_addr.size();
    o0 = obs_addr.size(); e0 = en_cyc.size(); d0 = done_cyc.size();
    bus.out_ready = 1'b1;
    start_scan(b, l, s);
    drive_until_done(80, 0, to);
    checks++; if (to) begin failures++; $display("FAIL full_timeout base=%0d len=%0d got=timeout exp=done", b, l); end
    checks++; if (obs_addr.size() - o0 != n) begin failures++; $display("FAIL full_count got=%0d exp=%0d", obs_addr.size() - o0, n); end
    checks++;
    if (en_cyc.size() <= e0) begin failures++; $display("FAIL first_rom_en got=none exp=%0d", s); end
    else if (en_cyc[e0] != s) begin failures++; $display("FAIL first_rom_en got=%0d exp=%0d", en_cyc[e0], s); end
    for (int i = 0; i < n && (o0 + i) < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[o0+i] != exp_addr[i] || obs_data[o0+i] != exp_data[i] || obs_cyc[o0+i] != s + 2 + i) begin
        failures++;
        $display("FAIL full_xfer%0d got=a%0d/d%0d/c%0d exp=a%0d/d%0d/c%0d", i, obs_addr[o0+i], obs_data[o0+i],
                 obs_cyc[o0+i], exp_addr[i], exp_data[i], s + 2 + i);
      end
    end
    checks++; if (done_cyc.size() - d0 != 1) begin failures++; $display("FAIL full_done_count got=%0d exp=1", done_cyc.size() - d0); end
    checks++;
    if (done_cyc.size() > d0 && (done_cyc[d0] != s + 2 + n || done_busy[d0] != 0)) begin
      failures++; $display("FAIL full_done_cycle got=c%0d/busy%0d exp=c%0d/busy0", done_cyc[d0], done_busy[d0], s + 2 + n);
    end
    checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL full_idle got=busy%0b/valid%0b exp=0/0", bus.busy, bus.out_valid); end
    checks++; if (msb_bad != 0) begin failures++; $display("FAIL rom_addr_msb got=%0d exp=0", msb_bad); end
  endtask

  task automatic test_backpressure();
    int s, o0, b, ha, hd;
    bit to;
    b = $urandom_range(0, 15);
    for (int i = 0; i < 16; i++) rom[i] = DW'($urandom);
    build_exp(b, 8);
    o0 = obs_addr.size();
    bus.out_ready = 1'b1;
    start_scan(b, 8, s);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (obs_addr.size() - o0 >= 2) break;
    end
    bus.out_ready = 1'b0;
    @(negedge clk);
    ha = int'(bus.out_addr); hd = int'(bus.out_data);
    checks++; if (ha != exp_addr[2] || hd != exp_data[2]) begin failures++; $display("FAIL stall_head got=a%0d/d%0d exp=a%0d/d%0d", ha, hd, exp_addr[2], exp_data[2]); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || int'(bus.out_addr) != ha || int'(bus.out_data) != hd) begin
        failures++; $display("FAIL stall_stable%0d got=v%0b/a%0d/d%0d exp=v1/a%0d/d%0d", i, bus.out_valid, bus.out_addr, bus.out_data, ha, hd);
      end
      if (i >= 2) begin
        checks++; if (bus.rom_en !== 1'b0) begin failures++; $display("FAIL stall_rom_en%0d got=%0b exp=0", i, bus.rom_en); end
      end
    end
    bus.out_ready = 1'b1;
    drive_until_done(80, 0, to);
    checks++; if (to) begin failures++; $display("FAIL stall_timeout got=timeout exp=done"); end
    checks++; if (obs_addr.size() - o0 != 8) begin failures++; $display("FAIL stall_count got=%0d exp=8", obs_addr.size() - o0); end
    for (int i = 0; i < 8 && (o0 + i) < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[o0+i] != exp_addr[i] || obs_data[o0+i] != exp_data[i]) begin
        failures++; $display("FAIL stall_xfer%0d got=a%0d/d%0d exp=a%0d/d%0d", i, obs_addr[o0+i], obs_data[o0+i], exp_addr[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int s, o0, d0;
    bit to;
    for (int i = 0; i < 16; i++) rom[i] = DW'($urandom);
    build_exp(11, 6);
    o0 = obs_addr.size(); d0 = done_cyc.size();
    bus.out_ready = 1'b1;
    start_scan(11, 6, s);
    @(posedge clk); #1;
    bus.out_ready = 1'($urandom_range(0, 1));
    bus.start = 1'b1; bus.base = 4'd2; bus.len = 4'd3;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drive_until_done(120, 1, to);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (to) begin failures++; $display("FAIL ignore_timeout got=timeout exp=done"); end
    checks++; if (obs_addr.size() - o0 != 6) begin failures++; $display("FAIL ignore_count got=%0d exp=6", obs_addr.size() - o0); end
    for (int i = 0; i < 6 && (o0 + i) < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[o0+i] != exp_addr[i] || obs_data[o0+i] != exp_data[i]) begin
        failures++; $display("FAIL ignore_xfer%0d got=a%0d/d%0d exp=a%0d/d%0d", i, obs_addr[o0+i], obs_data[o0+i], exp_addr[i], exp_data[i]);
      end
    end
    checks++; if (done_cyc.size() - d0 != 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", done_cyc.size() - d0); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL ignore_busy_after got=%0b exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid_scan();
    int s, o0, d0;
    bit to;
    for (int i = 0; i < 16; i++) rom[i] = DW'($urandom);
    bus.out_ready = 1'b0;
    start_scan(9, 8, s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%0b exp=1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rom_en !== 1'b0 || bus.rom_addr !== 5'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 4'd0 ||
        bus.out_addr !== 4'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=en%0b/ra%0d/v%0b/d%0d/a%0d/b%0b/dn%0b exp=all0", bus.rom_en, bus.rom_addr,
               bus.out_valid, bus.out_data, bus.out_addr, bus.busy, bus.done);
    end
    @(posedge clk); #1;
    build_exp(3, 2);
    o0 = obs_addr.size(); d0 = done_cyc.size();
    bus.out_ready = 1'b1;
    start_scan(3, 2, s);
    drive_until_done(60, 0, to);
    checks++; if (to) begin failures++; $display("FAIL mid_timeout got=timeout exp=done"); end
    checks++; if (obs_addr.size() - o0 != 2) begin failures++; $display("FAIL mid_count got=%0d exp=2", obs_addr.size() - o0); end
    for (int i = 0; i < 2 && (o0 + i) < obs_addr.size(); i++) begin
      checks++;
      if (obs_addr[o0+i] != exp_addr[i] || obs_data[o0+i] != exp_data[i]) begin
        failures++; $display("FAIL mid_xfer%0d got=a%0d/d%0d exp=a%0d/d%0d", i, obs_addr[o0+i], obs_data[o0+i], exp_addr[i], exp_data[i]);
      end
    end
    checks++; if (done_cyc.size() - d0 != 1) begin failures++; $display("FAIL mid_done_count got=%0d exp=1", done_cyc.size() - d0); end
  endtask

  initial begin
    test_reset();
    rom[0] = 4'd2; rom[1] = 4'd2; rom[2] = 4'd14; rom[3] = 4'd2;
    test_full_rate(0, 4);
    test_full_rate(14, 4);
    test_full_rate(5, 0);
    test_full_rate($urandom_range(0, 15), $urandom_range(1, 15));
    test_backpressure();
    test_start_ignored();
    test_reset_mid_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
